// File: rtl/id_ex_stage_if.sv
// Bundles the decode-side, bypass-source and ALU-side signals of the ID/EX stage.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface id_ex_stage_if #(parameter int unsigned XLEN = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [3:0]      in_alu_op;
   logic [4:0]      in_rs1_addr;
   logic [4:0]      in_rs2_addr;
   logic [XLEN-1:0] in_rs1_data;
   logic [XLEN-1:0] in_rs2_data;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [4:0]      in_rd_addr;
   logic            in_rd_wen;
   logic [4:0]      ex_rd_addr;
   logic            ex_rd_wen;
   logic [XLEN-1:0] ex_rd_data;
   logic            ex_is_load;
   logic [4:0]      wb_rd_addr;
   logic            wb_rd_wen;
   logic [XLEN-1:0] wb_rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [3:0]      out_alu_op;
   logic [XLEN-1:0] out_rs1;
   logic [XLEN-1:0] out_rs2;
   logic [4:0]      out_rd_addr;
   logic            out_rd_wen;

   modport slave (
      input  flush, in_valid, in_pc, in_alu_op, in_rs1_addr, in_rs2_addr,
             in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_rd_wen,
             ex_rd_addr, ex_rd_wen, ex_rd_data, ex_is_load,
             wb_rd_addr, wb_rd_wen, wb_rd_data, out_ready,
      output in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2,
             out_rd_addr, out_rd_wen
   );

   modport master (
      output flush, in_valid, in_pc, in_alu_op, in_rs1_addr, in_rs2_addr,
             in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_rd_wen,
             ex_rd_addr, ex_rd_wen, ex_rd_data, ex_is_load,
             wb_rd_addr, wb_rd_wen, wb_rd_data, out_ready,
      input  in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2,
             out_rd_addr, out_rd_wen
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operands, detects RAW hazards, registers ALU inputs.
// Define ID_EX_FWD_EN to enable the EX/WB bypass network (load-use stall only).
module id_ex_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e          state_q;
   logic [XLEN-1:0] pc_q;
   logic [3:0]      alu_op_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [4:0]      rd_addr_q;
   logic            rd_wen_q;

   logic [XLEN-1:0] rs1_d;
   logic [XLEN-1:0] rs2_d;
   logic            held_hit;
   logic            ex_hit1, ex_hit2, wb_hit1, wb_hit2;
   logic            hazard;
   logic            in_ready;
   logic            accept;

   // A write to x0 never produces a dependency, so dst==0 never matches.
   function automatic logic src_hit(input logic [4:0] dst, input logic wen,
                                    input logic [4:0] src);
      return wen && (dst != 5'd0) && (dst == src);
   endfunction

   always_comb begin
      held_hit = 1'b0;
      ex_hit1  = src_hit(bus.ex_rd_addr, bus.ex_rd_wen, bus.in_rs1_addr);
      ex_hit2  = src_hit(bus.ex_rd_addr, bus.ex_rd_wen, bus.in_rs2_addr) && !bus.in_use_imm;
      wb_hit1  = src_hit(bus.wb_rd_addr, bus.wb_rd_wen, bus.in_rs1_addr);
      wb_hit2  = src_hit(bus.wb_rd_addr, bus.wb_rd_wen, bus.in_rs2_addr) && !bus.in_use_imm;
      if (state_q == FULL) begin
         held_hit = src_hit(rd_addr_q, rd_wen_q, bus.in_rs1_addr) ||
                    (src_hit(rd_addr_q, rd_wen_q, bus.in_rs2_addr) && !bus.in_use_imm);
      end
`ifdef ID_EX_FWD_EN
      hazard = bus.in_valid && (held_hit || (bus.ex_is_load && (ex_hit1 || ex_hit2)));
`else
      hazard = bus.in_valid && (held_hit || ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2);
`endif
      in_ready = !hazard && ((state_q == EMPTY) || bus.out_ready);
      accept   = bus.in_valid && in_ready && !bus.flush;
   end

   // Operand resolution; x0 reads as zero regardless of any bypass source.
   always_comb begin
      rs1_d = '0;
      rs2_d = '0;
      if (bus.in_rs1_addr != 5'd0) begin
`ifdef ID_EX_FWD_EN
         if (ex_hit1)      rs1_d = bus.ex_rd_data;
         else if (wb_hit1) rs1_d = bus.wb_rd_data;
         else              rs1_d = bus.in_rs1_data;
`else
         rs1_d = bus.in_rs1_data;
`endif
      end
      if (bus.in_use_imm) begin
         rs2_d = bus.in_imm;
      end else if (bus.in_rs2_addr != 5'd0) begin
`ifdef ID_EX_FWD_EN
         if (ex_hit2)      rs2_d = bus.ex_rd_data;
         else if (wb_hit2) rs2_d = bus.wb_rd_data;
         else              rs2_d = bus.in_rs2_data;
`else
         rs2_d = bus.in_rs2_data;
`endif
      end
   end

`ifndef ID_EX_FWD_EN
   logic unused_bypass;
   assign unused_bypass = ^{bus.ex_rd_data, bus.wb_rd_data, bus.ex_is_load};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         pc_q      <= '0;
         alu_op_q  <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_addr_q <= '0;
         rd_wen_q  <= 1'b0;
      end else if (bus.flush) begin
         state_q <= EMPTY;
      end else if (accept) begin
         state_q   <= FULL;
         pc_q      <= bus.in_pc;
         alu_op_q  <= bus.in_alu_op;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_addr_q <= bus.in_rd_addr;
         rd_wen_q  <= bus.in_rd_wen;
      end else if (bus.out_ready) begin
         state_q <= EMPTY;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = (state_q == FULL);
   assign bus.out_pc      = pc_q;
   assign bus.out_alu_op  = alu_op_q;
   assign bus.out_rs1     = rs1_q;
   assign bus.out_rs2     = rs2_q;
   assign bus.out_rd_addr = rd_addr_q;
   assign bus.out_rd_wen  = rd_wen_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; follows ID_EX_FWD_EN like the design.
module tb_id_ex_stage;
   localparam int unsigned XLEN = 32;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   id_ex_stage_if #(.XLEN(XLEN)) bus ();

   id_ex_stage #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.flush       = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_pc       = '0;
      bus.in_alu_op   = '0;
      bus.in_rs1_addr = '0;
      bus.in_rs2_addr = '0;
      bus.in_rs1_data = '0;
      bus.in_rs2_data = '0;
      bus.in_imm      = '0;
      bus.in_use_imm  = 1'b0;
      bus.in_rd_addr  = '0;
      bus.in_rd_wen   = 1'b0;
      bus.ex_rd_addr  = '0;
      bus.ex_rd_wen   = 1'b0;
      bus.ex_rd_data  = '0;
      bus.ex_is_load  = 1'b0;
      bus.wb_rd_addr  = '0;
      bus.wb_rd_wen   = 1'b0;
      bus.wb_rd_data  = '0;
      bus.out_ready   = 1'b1;
   endtask

   task automatic drain;
      idle_inputs();
      tick();
   endtask

   task automatic test_reset;
      idle_inputs();
      rst             = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_pc       = 32'h100;
      bus.in_alu_op   = 4'd3;
      bus.in_rs1_addr = 5'd1;
      bus.in_rs1_data = 32'h11;
      bus.in_rs2_addr = 5'd2;
      bus.in_rs2_data = 32'h22;
      bus.in_rd_addr  = 5'd3;
      bus.in_rd_wen   = 1'b1;
      bus.out_ready   = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid);
      end
      checks++;
      if ({bus.out_pc, bus.out_alu_op, bus.out_rs1, bus.out_rs2, bus.out_rd_addr, bus.out_rd_wen} !== '0) begin
         failures++;
         $display("FAIL reset_data got pc=%h op=%h rs1=%h rs2=%h rd=%h wen=%b exp=all zero",
                  bus.out_pc, bus.out_alu_op, bus.out_rs1, bus.out_rs2, bus.out_rd_addr, bus.out_rd_wen);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_alu_op !== 4'd3) begin
         failures++;
         $display("FAIL release_capture got v=%b pc=%h op=%h exp v=1 pc=100 op=3",
                  bus.out_valid, bus.out_pc, bus.out_alu_op);
      end
      checks++;
      if (bus.out_rs1 !== 32'h11 || bus.out_rs2 !== 32'h22 || bus.out_rd_addr !== 5'd3 || bus.out_rd_wen !== 1'b1) begin
         failures++;
         $display("FAIL release_operands got rs1=%h rs2=%h rd=%h wen=%b exp 11 22 3 1",
                  bus.out_rs1, bus.out_rs2, bus.out_rd_addr, bus.out_rd_wen);
      end
   endtask

   task automatic test_backpressure;
      bus.in_pc       = 32'h200;
      bus.in_alu_op   = 4'd5;
      bus.in_rs1_addr = 5'd4;
      bus.in_rs1_data = 32'h44;
      bus.in_use_imm  = 1'b1;
      bus.in_imm      = 32'h55;
      bus.in_rd_addr  = 5'd6;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL stall_ready got=%0b exp=0", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_rs1 !== 32'h11) begin
            failures++;
            $display("FAIL hold_cycle%0d got v=%b pc=%h rs1=%h exp v=1 pc=100 rs1=11",
                     i, bus.out_valid, bus.out_pc, bus.out_rs1);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL drain_ready got=%0b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_pc !== 32'h200 || bus.out_alu_op !== 4'd5 || bus.out_rs1 !== 32'h44 || bus.out_rs2 !== 32'h55) begin
         failures++;
         $display("FAIL next_capture got pc=%h op=%h rs1=%h rs2=%h exp 200 5 44 55",
                  bus.out_pc, bus.out_alu_op, bus.out_rs1, bus.out_rs2);
      end
   endtask

   task automatic test_flush;
      bus.in_pc = 32'h300;
      bus.flush = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL flush_ready got=%0b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_kill got=%0b exp=0", bus.out_valid);
      end
      drain();
   endtask

`ifdef ID_EX_FWD_EN
   task automatic test_bypass;
      idle_inputs();
      bus.in_valid    = 1'b1;
      bus.in_pc       = 32'h500;
      bus.in_rs1_addr = 5'd5;
      bus.in_rs1_data = 32'hCC;
      bus.ex_rd_addr  = 5'd5; bus.ex_rd_wen = 1'b1; bus.ex_rd_data = 32'hAA;
      bus.wb_rd_addr  = 5'd5; bus.wb_rd_wen = 1'b1; bus.wb_rd_data = 32'hBB;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL fwd_ready got=%0b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_rs1 !== 32'hAA) begin
         failures++; $display("FAIL fwd_ex got=%h exp=aa", bus.out_rs1);
      end
      bus.ex_rd_wen = 1'b0;
      tick();
      checks++;
      if (bus.out_rs1 !== 32'hBB) begin
         failures++; $display("FAIL fwd_wb got=%h exp=bb", bus.out_rs1);
      end
      bus.ex_rd_wen   = 1'b1;
      bus.in_rs1_addr = 5'd0;
      tick();
      checks++;
      if (bus.out_rs1 !== 32'h0) begin
         failures++; $display("FAIL fwd_x0 got=%h exp=0", bus.out_rs1);
      end
      bus.in_rs1_addr = 5'd5;
      bus.ex_is_load  = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL load_use got=%0b exp=0", bus.in_ready);
      end
      drain();
   endtask
`else
   task automatic test_no_bypass;
      idle_inputs();
      bus.in_valid    = 1'b1;
      bus.in_pc       = 32'h500;
      bus.in_rs1_addr = 5'd5;
      bus.in_rs1_data = 32'hCC;
      bus.ex_rd_addr  = 5'd5; bus.ex_rd_wen = 1'b1; bus.ex_rd_data = 32'hAA;
      bus.wb_rd_addr  = 5'd5; bus.wb_rd_wen = 1'b1; bus.wb_rd_data = 32'hBB;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL raw_both got=%0b exp=0", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL raw_hold got v=%b rdy=%b exp v=0 rdy=0", bus.out_valid, bus.in_ready);
      end
      bus.ex_rd_wen = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL raw_wb got=%0b exp=0", bus.in_ready);
      end
      bus.wb_rd_wen = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL raw_clear got=%0b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_rs1 !== 32'hCC) begin
         failures++; $display("FAIL rf_operand got v=%b rs1=%h exp v=1 rs1=cc", bus.out_valid, bus.out_rs1);
      end
      drain();
   endtask
`endif

   task automatic test_imm_hazard;
      idle_inputs();
      bus.in_valid   = 1'b1;
      bus.in_pc      = 32'h400;
      bus.in_rd_addr = 5'd7;
      bus.in_rd_wen  = 1'b1;
      bus.out_ready  = 1'b0;
      tick();
      bus.in_pc       = 32'h404;
      bus.in_rs1_addr = 5'd1;
      bus.in_rs1_data = 32'h1;
      bus.in_rs2_addr = 5'd7;
      bus.in_rs2_data = 32'h77;
      bus.in_use_imm  = 1'b1;
      bus.in_imm      = 32'h10;
      bus.out_ready   = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL imm_nostall got=%0b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_pc !== 32'h404 || bus.out_rs2 !== 32'h10) begin
         failures++; $display("FAIL imm_operand got pc=%h rs2=%h exp 404 10", bus.out_pc, bus.out_rs2);
      end
      bus.in_pc      = 32'h408;
      bus.in_use_imm = 1'b0;
      bus.in_rd_addr = 5'd8;
      bus.out_ready  = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL rs2_stall got=%0b exp=0", bus.in_ready);
      end
      tick();
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h404) begin
         failures++; $display("FAIL rs2_held got rdy=%b pc=%h exp rdy=0 pc=404", bus.in_ready, bus.out_pc);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL rs2_release got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h408 || bus.out_rs2 !== 32'h77) begin
         failures++;
         $display("FAIL rs2_capture got v=%b pc=%h rs2=%h exp v=1 pc=408 rs2=77", bus.out_valid, bus.out_pc, bus.out_rs2);
      end
      drain();
   endtask

   task automatic test_async_reset_mid;
      idle_inputs();
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'h600;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
         failures++; $display("FAIL async_reset got v=%b pc=%h exp v=0 pc=0", bus.out_valid, bus.out_pc);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL post_reset_empty got=%0b exp=0", bus.out_valid);
      end
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h604;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h604) begin
         failures++; $display("FAIL post_reset_accept got v=%b pc=%h exp v=1 pc=604", bus.out_valid, bus.out_pc);
      end
      drain();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      test_reset();
      test_backpressure();
      test_flush();
`ifdef ID_EX_FWD_EN
      test_bypass();
`else
      test_no_bypass();
`endif
      test_imm_hazard();
      test_async_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
